mdiv_unit: RTL and testbench
============================

Name: mdiv_unit

Overview:
Iterative integer multiply/divide unit in the M stage of the 5-stage MIPS core. It owns the HI/LO architectural registers and executes MULT/MULTU/DIV/DIVU over multiple cycles while the rest of the pipeline keeps running. It drives the busy flag that the hazard unit combines with the M-stage MFHI/MFLO select to stall the pipeline. MTHI/MTLO writes and MFHI/MFLO reads (HI/LO outputs) also pass through this block.

Parameters:
DATA_W, 32, operand/HI/LO width; counter width is clog2(DATA_W)+1.

Ports:
CLK  in  1  core clock
RESET  in  1  synchronous, active-high reset
START  in  1  launch operation; single-cycle pulse, sampled at rising edge
OP  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
SRC_A  in  DATA_W  rs operand (multiplicand / dividend)
SRC_B  in  DATA_W  rt operand (multiplier / divisor)
MTHI  in  1  write SRC_A to HI
MTLO  in  1  write SRC_A to LO
BUSY  out  1  operation in flight (registered); feeds hazard unit MDIV_BUSY_M
HI  out  DATA_W  HI register (product[63:32] / remainder)
LO  out  DATA_W  LO register (product[31:0] / quotient)

Behaviour:
- Clocking: single clock CLK; RESET synchronous, active-high, has priority over all inputs.
- Reset: state IDLE, BUSY=0, HI=0, LO=0, counter=0. Reset mid-operation discards the operation and gives no partial HI/LO update.
- FSM: IDLE -> CALC -> FIX -> IDLE.
  - IDLE: START loads operands and goes to CALC; counter=DATA_W; BUSY=1 at the same edge.
  - CALC: one radix-2 step per cycle (shift-add multiply / restoring divide on magnitudes); counter decrements; at counter==1 -> FIX.
  - FIX: apply sign correction and write HI/LO; BUSY=0 at the same edge; -> IDLE.
- Latency: START sampled at edge k; BUSY=1 after edges k..k+DATA_W; HI/LO and BUSY=0 update at edge k+DATA_W+1 (33 edges for DATA_W=32). An MFHI/MFLO one instruction behind the op therefore sees BUSY=1 in M.
- Signed ops: operate on |a|,|b| (|-2^31| = 2^31 as unsigned).
  - Product sign = sa^sb: negate the full 2*DATA_W product.
  - Quotient sign = sa^sb; remainder sign = sa.
- Unsigned ops: no fixup. FIX still takes one cycle so latency is uniform.
- Divide by zero (DIV or DIVU): LO = all ones, HI = SRC_A unmodified. No exception, same latency.
- Signed overflow 0x80000000 / -1: LO=0x80000000, HI=0 (falls out of the magnitude algorithm).
- START while BUSY: abort the current op and restart with the new operands. Counter reloads and BUSY stays 1; HI/LO keep their pre-abort values.
- MTHI/MTLO: write HI/LO at the next edge. If BUSY, the op is aborted and BUSY=0 at the same edge.
- Simultaneous events:
  - START together with MTHI/MTLO: START wins and the MT write is dropped (cannot occur from one instruction).
  - MTHI and MTLO together: both written.
- HI/LO outputs always show the registers directly. Values during BUSY are stale, and the hazard unit must stall readers.
- Internal working registers: 2*DATA_W accumulator / remainder-quotient register, operand register, sign flags, op-type flag.

Decomposition:
- Shared package (cpu_pkg): mdiv_op_t enum (MDIV_MULT, MDIV_MULTU, MDIV_DIV, MDIV_DIVU) and the mdiv_state_t enum.
- One natural sub-module: mdiv_step, a combinational single-iteration datapath (shift-add or trial-subtract select). The FSM, counter and HI/LO registers stay in mdiv_unit.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> BUSY high exactly 33 cycles; then HI=0xFFFFFFFE, LO=0x00000001.
- MULT -3 x 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 100 / 0 -> LO=0xFFFFFFFF, HI=0x00000064. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 100/7 started, second START (MULTU 5x6) at cycle 10 -> BUSY continuous; 33 edges after the restart HI=0, LO=30, and no 14/2 result ever appears.
- MTLO 0x1234 during busy MULT (cycle 5) -> next edge LO=0x1234, BUSY=0, HI unchanged.
- RESET asserted at cycle 20 of a DIV -> next edge BUSY=0, HI=LO=0; a following START behaves normally.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types for the core's multiply/divide unit.
//   mdiv_op_t    : operation encoding carried on OP
//   mdiv_state_t : sequencer state of mdiv_unit (also visible on DBG_STATE)
package cpu_pkg;

  typedef enum logic [1:0] {
    MDIV_MULT  = 2'b00,
    MDIV_MULTU = 2'b01,
    MDIV_DIV   = 2'b10,
    MDIV_DIVU  = 2'b11
  } mdiv_op_t;

  typedef enum logic [1:0] {
    MDIV_IDLE = 2'b00,
    MDIV_CALC = 2'b01,
    MDIV_FIX  = 2'b10
  } mdiv_state_t;

  // Signed ops need magnitude conversion and a sign fixup in FIX.
  function automatic logic op_is_signed(input mdiv_op_t op);
    return (op == MDIV_MULT) || (op == MDIV_DIV);
  endfunction

  function automatic logic op_is_div(input mdiv_op_t op);
    return (op == MDIV_DIV) || (op == MDIV_DIVU);
  endfunction

endpackage

// File: rtl/mdiv_step.sv
// One radix-2 iteration of the multiply/divide datapath (combinational).
//   is_div   : 1 = restoring-divide step, 0 = shift-add multiply step
//   acc      : {upper, lower} working register
//              multiply: {partial product high, remaining multiplier bits}
//              divide:   {partial remainder, dividend bits / quotient bits}
//   opnd     : multiplicand magnitude (multiply) or divisor magnitude (divide)
//   acc_next : working register after this iteration
module mdiv_step #(
  parameter int DATA_W = 32
) (
  input  logic                  is_div,
  input  logic [2*DATA_W-1:0]   acc,
  input  logic [DATA_W-1:0]     opnd,
  output logic [2*DATA_W-1:0]   acc_next
);

  logic [DATA_W:0] add_sum;
  logic [DATA_W:0] trial;

  always_comb begin
    // Multiply: add the multiplicand when the current multiplier LSB is set,
    // keep the carry, then shift the whole register right by one.
    add_sum = {1'b0, acc[2*DATA_W-1:DATA_W]} +
              (acc[0] ? {1'b0, opnd} : {(DATA_W+1){1'b0}});

    // Divide: the remainder shifted left by one is acc[2W-1:W-1] (W+1 bits).
    // It is always below 2*divisor, so a W+1-bit difference cannot wrap and
    // its MSB is a valid "went negative" flag.
    trial = acc[2*DATA_W-1:DATA_W-1] - {1'b0, opnd};

    acc_next = {add_sum, acc[DATA_W-1:1]};
    if (is_div) begin
      if (!trial[DATA_W]) begin
        acc_next = {trial[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
      end else begin
        acc_next = {acc[2*DATA_W-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/mdiv_unit.sv
// Iterative multiply/divide unit with the HI/LO architectural registers.
//   CLK, RESET      : clock, synchronous active-high reset
//   START, OP       : launch MULT/MULTU/DIV/DIVU (single-cycle pulse)
//   SRC_A, SRC_B    : rs / rt operands; SRC_A is also the MTHI/MTLO data
//   MTHI, MTLO      : write SRC_A into HI / LO (aborts an op in flight)
//   BUSY            : op in flight, registered
//   HI, LO          : architectural registers, shown directly (stale while BUSY)
//   DBG_STATE       : current sequencer state (mdiv_state_t encoding)
//
// Handshake: START is accepted at any edge it is high (no ready); it restarts
// an op already in flight. BUSY rises at the accepting edge and falls at the
// edge HI/LO are written, DATA_W+1 edges later. MTHI/MTLO are accepted at any
// edge without START and take effect at that edge.
module mdiv_unit
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic [1:0]        OP,
  input  logic [DATA_W-1:0] SRC_A,
  input  logic [DATA_W-1:0] SRC_B,
  input  logic              MTHI,
  input  logic              MTLO,
  output logic              BUSY,
  output logic [DATA_W-1:0] HI,
  output logic [DATA_W-1:0] LO,
  output logic [1:0]        DBG_STATE
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  mdiv_state_t          state;
  logic [CNT_W-1:0]     cnt;
  logic [2*DATA_W-1:0]  acc;
  logic [DATA_W-1:0]    opnd;
  logic [DATA_W-1:0]    src_a_q;     // raw dividend, returned in HI on /0
  logic                 is_div_q;
  logic                 neg_q;       // negate product / quotient
  logic                 neg_r;       // negate remainder
  logic                 div_zero_q;

  logic [2*DATA_W-1:0]  acc_next;
  mdiv_op_t             op_in;
  logic                 sgn_in;
  logic                 sa_in;
  logic                 sb_in;
  logic [DATA_W-1:0]    mag_a;
  logic [DATA_W-1:0]    mag_b;
  logic [2*DATA_W-1:0]  prod_fix;
  logic [DATA_W-1:0]    quot_fix;
  logic [DATA_W-1:0]    rem_fix;

  assign op_in  = mdiv_op_t'(OP);
  assign sgn_in = op_is_signed(op_in);
  assign sa_in  = sgn_in & SRC_A[DATA_W-1];
  assign sb_in  = sgn_in & SRC_B[DATA_W-1];
  // Negating the most negative value wraps to itself, which read as unsigned
  // is exactly its magnitude, so no extra bit is needed.
  assign mag_a  = sa_in ? (~SRC_A + 1'b1) : SRC_A;
  assign mag_b  = sb_in ? (~SRC_B + 1'b1) : SRC_B;

  // Sign fixups; neg_q/neg_r are only ever set for signed ops.
  assign prod_fix = neg_q ? (~acc + 1'b1) : acc;
  assign quot_fix = neg_q ? (~acc[DATA_W-1:0] + 1'b1) : acc[DATA_W-1:0];
  assign rem_fix  = neg_r ? (~acc[2*DATA_W-1:DATA_W] + 1'b1)
                          : acc[2*DATA_W-1:DATA_W];

  assign DBG_STATE = state;

  mdiv_step #(.DATA_W(DATA_W)) u_step (
    .is_div   (is_div_q),
    .acc      (acc),
    .opnd     (opnd),
    .acc_next (acc_next)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= MDIV_IDLE;
      BUSY       <= 1'b0;
      HI         <= '0;
      LO         <= '0;
      cnt        <= '0;
      acc        <= '0;
      opnd       <= '0;
      src_a_q    <= '0;
      is_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      div_zero_q <= 1'b0;
    end else if (START) begin
      // Launch or restart; any MT write in the same cycle is dropped.
      state      <= MDIV_CALC;
      BUSY       <= 1'b1;
      cnt        <= CNT_W'(DATA_W);
      is_div_q   <= op_is_div(op_in);
      neg_q      <= sa_in ^ sb_in;
      neg_r      <= sa_in;
      src_a_q    <= SRC_A;
      div_zero_q <= op_is_div(op_in) && (SRC_B == '0);
      if (op_is_div(op_in)) begin
        acc  <= {{DATA_W{1'b0}}, mag_a};
        opnd <= mag_b;
      end else begin
        acc  <= {{DATA_W{1'b0}}, mag_b};
        opnd <= mag_a;
      end
    end else if (MTHI || MTLO) begin
      if (MTHI) HI <= SRC_A;
      if (MTLO) LO <= SRC_A;
      state <= MDIV_IDLE;
      BUSY  <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        MDIV_CALC: begin
          acc <= acc_next;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= MDIV_FIX;
        end
        MDIV_FIX: begin
          if (!is_div_q) begin
            HI <= prod_fix[2*DATA_W-1:DATA_W];
            LO <= prod_fix[DATA_W-1:0];
          end else if (div_zero_q) begin
            HI <= src_a_q;
            LO <= '1;
          end else begin
            HI <= rem_fix;
            LO <= quot_fix;
          end
          BUSY  <= 1'b0;
          state <= MDIV_IDLE;
        end
        default: begin
          state <= MDIV_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdiv_unit.sv
module tb_mdiv_unit;

  localparam int W = 32;

  logic         CLK = 1'b0;
  logic         RESET;
  logic         START;
  logic [1:0]   OP;
  logic [W-1:0] SRC_A;
  logic [W-1:0] SRC_B;
  logic         MTHI;
  logic         MTLO;
  logic         BUSY;
  logic [W-1:0] HI;
  logic [W-1:0] LO;
  logic [1:0]   DBG_STATE;

  int checks = 0;
  int errors = 0;

  logic [2*W-1:0] exp_q[$];
  logic [W-1:0]   model_hi;
  logic [W-1:0]   model_lo;

  mdiv_unit #(.DATA_W(W)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .START     (START),
    .OP        (OP),
    .SRC_A     (SRC_A),
    .SRC_B     (SRC_B),
    .MTHI      (MTHI),
    .MTLO      (MTLO),
    .BUSY      (BUSY),
    .HI        (HI),
    .LO        (LO),
    .DBG_STATE (DBG_STATE)
  );

  // ---------------- clock / watchdog ----------------
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // MIPS semantics straight from integer arithmetic.
  function automatic logic [2*W-1:0] model(input logic [1:0] op,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    int          sa;
    int          sb;
    longint      sp;
    logic [63:0] up;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    sa = a;
    sb = b;
    hi = '0;
    lo = '0;
    case (op)
      2'b00: begin sp = longint'(sa) * longint'(sb); hi = sp[63:32]; lo = sp[31:0]; end
      2'b01: begin up = {32'b0, a} * {32'b0, b}; hi = up[63:32]; lo = up[31:0]; end
      2'b10: begin
        if (b == 0) begin lo = '1; hi = a; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin lo = a; hi = 0; end
        else begin lo = sa / sb; hi = sa % sb; end
      end
      default: begin
        if (b == 0) begin lo = '1; hi = a; end
        else begin lo = a / b; hi = a % b; end
      end
    endcase
    return {hi, lo};
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_start(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge CLK);
    START = 1'b1; OP = op; SRC_A = a; SRC_B = b;
    @(negedge CLK);
    START = 1'b0;
  endtask

  // Counts negedges with BUSY high; HI/LO must stay at the model's values.
  task automatic wait_done(output int n);
    n = 0;
    while (BUSY === 1'b1 && n < 100) begin
      check("stale_hi", HI, model_hi);
      check("stale_lo", LO, model_lo);
      n++;
      @(negedge CLK);
    end
    if (n >= 100) check("busy_bound", 32'(n), 32'd33);
  endtask

  task automatic check_result(input string tag);
    logic [2*W-1:0] e;
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_hi"}, HI, e[2*W-1:W]);
      check({tag, "_lo"}, LO, e[W-1:0]);
      check({tag, "_busy"}, {31'b0, BUSY}, 32'd0);
      model_hi = e[2*W-1:W];
      model_lo = e[W-1:0];
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    exp_q.push_back(model(op, a, b));
    drive_start(op, a, b);
    wait_done(n);
    check({tag, "_len"}, 32'(n), 32'd33);
    check_result(tag);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int n;
    logic [1:0]   rop;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    RESET = 1'b1; START = 1'b0; OP = 2'b00; SRC_A = '0; SRC_B = '0;
    MTHI = 1'b0; MTLO = 1'b0;
    model_hi = '0; model_lo = '0;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    check("rst_busy", {31'b0, BUSY}, 32'd0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_max_hi_const", HI, 32'hFFFF_FFFE);
    check("multu_max_lo_const", LO, 32'h0000_0001);
    run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7);
    run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2);
    check("div_neg_lo_const", LO, 32'hFFFF_FFFD);
    run_op("divu_zero", 2'b11, 32'd100, 32'd0);
    run_op("div_zero", 2'b10, 32'hFFFF_FF00, 32'd0);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("mult_min", 2'b00, 32'h8000_0000, 32'h8000_0000);
    run_op("div_rem_neg", 2'b10, 32'hFFFF_FF9C, 32'd7);

    // Restart mid-op: DIVU 100/7 then MULTU 5x6 ten edges later.
    drive_start(2'b11, 32'd100, 32'd7);
    repeat (8) begin
      check("abort_busy", {31'b0, BUSY}, 32'd1);
      @(negedge CLK);
    end
    exp_q.push_back(model(2'b01, 32'd5, 32'd6));
    drive_start(2'b01, 32'd5, 32'd6);
    wait_done(n);
    check("restart_len", 32'(n), 32'd33);
    check_result("restart");
    repeat (40) @(negedge CLK);
    check("restart_hold_hi", HI, 32'd0);
    check("restart_hold_lo", LO, 32'd30);

    // MTLO during a busy MULT aborts it.
    drive_start(2'b00, 32'h0001_2345, 32'h0000_0777);
    repeat (4) @(negedge CLK);
    MTLO = 1'b1; SRC_A = 32'h0000_1234;
    @(negedge CLK);
    MTLO = 1'b0;
    check("mtlo_lo", LO, 32'h0000_1234);
    check("mtlo_hi", HI, model_hi);
    check("mtlo_busy", {31'b0, BUSY}, 32'd0);
    model_lo = 32'h0000_1234;
    repeat (40) @(negedge CLK);
    check("mtlo_hold_lo", LO, model_lo);
    check("mtlo_hold_hi", HI, model_hi);

    // MTHI and MTLO together.
    @(negedge CLK);
    MTHI = 1'b1; MTLO = 1'b1; SRC_A = 32'hA5A5_5A5A;
    @(negedge CLK);
    MTHI = 1'b0; MTLO = 1'b0;
    check("mtboth_hi", HI, 32'hA5A5_5A5A);
    check("mtboth_lo", LO, 32'hA5A5_5A5A);
    model_hi = 32'hA5A5_5A5A; model_lo = 32'hA5A5_5A5A;

    // START together with MTHI: op launches, MT write dropped.
    exp_q.push_back(model(2'b11, 32'd1000, 32'd33));
    @(negedge CLK);
    START = 1'b1; MTHI = 1'b1; OP = 2'b11; SRC_A = 32'd1000; SRC_B = 32'd33;
    @(negedge CLK);
    START = 1'b0; MTHI = 1'b0;
    check("start_mt_busy", {31'b0, BUSY}, 32'd1);
    wait_done(n);
    check("start_mt_len", 32'(n), 32'd33);
    check_result("start_mt");

    // Reset in the middle of a DIV.
    drive_start(2'b10, 32'hFFFF_F000, 32'd9);
    repeat (18) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    check("midrst_busy", {31'b0, BUSY}, 32'd0);
    check("midrst_hi", HI, 32'd0);
    check("midrst_lo", LO, 32'd0);
    model_hi = '0; model_lo = '0;
    repeat (40) @(negedge CLK);
    check("midrst_hold_hi", HI, 32'd0);
    check("midrst_hold_lo", LO, 32'd0);
    run_op("post_rst", 2'b10, 32'd77, 32'hFFFF_FFF6);

    // Random operations.
    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'($urandom_range(1, 15));
        3: ra = 32'h8000_0000;
        default: ;
      endcase
      run_op("rand", rop, ra, rb);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
